vid_cnt2sync: RTL

Video timing generator. Free-running horizontal/vertical counters produce registered hsync, vsync, data-enable, line-start and frame-start strobes. It is the transmit-side counterpart to the sync-to-counter recovery logic, and drives downstream pixel sources and the video output encoder. Its counter numbering matches the recovery logic exactly, so a loop-back yields identical hcnt/vcnt on both sides.

---
 rtl/vid_cnt2sync.sv | 118 +++++++++++
 1 files changed

// File: rtl/vid_cnt2sync.sv
// Video timing generator: free-running h/v counters with registered sync, DE and strobes.
// Optional VID_CNT2SYNC_GENLOCK_EN adds in_ext_fs to realign the frame to an external frame start.
module vid_cnt2sync #(
    parameter int unsigned H_ACTIVE      = 1280,
    parameter int unsigned H_FRONT_PORCH = 110,
    parameter int unsigned H_SYNC_WIDTH  = 40,
    parameter int unsigned H_BACK_PORCH  = 220,
    parameter int unsigned V_ACTIVE      = 720,
    parameter int unsigned V_FRONT_PORCH = 5,
    parameter int unsigned V_SYNC_WIDTH  = 5,
    parameter int unsigned V_BACK_PORCH  = 20,
    parameter bit          H_SYNC_POL    = 1'b1,
    parameter bit          V_SYNC_POL    = 1'b1,
    localparam int unsigned H_FRAME = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int unsigned V_FRAME = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int unsigned HW      = $clog2(H_FRAME),
    localparam int unsigned VW      = $clog2(V_FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
`ifdef VID_CNT2SYNC_GENLOCK_EN
    input  logic          in_ext_fs,
`endif
    output logic          out_valid,
    output logic [HW-1:0] out_hcnt,
    output logic [VW-1:0] out_vcnt,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_de,
    output logic          out_ls,
    output logic          out_fs
);

    localparam int unsigned HS_START = H_ACTIVE + H_FRONT_PORCH;
    localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT_PORCH;
    localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;
    logic          de_c, hs_c, vs_c, ls_c, fs_c;
    logic          load_zero;

`ifdef VID_CNT2SYNC_GENLOCK_EN
    logic ext_fs_q;
    logic pend_q, pend_d;

    // A fresh edge wins over consumption so an edge arriving on a load cycle is not lost.
    assign pend_d    = (pend_q & ~en) | (in_ext_fs & ~ext_fs_q);
    assign load_zero = pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_fs_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            ext_fs_q <= in_ext_fs;
            pend_q   <= pend_d;
        end
    end
`else
    assign load_zero = 1'b0;
`endif

    // Decodes are widened to 32 bits so end-of-range bounds equal to 2^HW do not truncate.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        h_last = (32'(h_q) == H_FRAME - 1);
        v_last = (32'(v_q) == V_FRAME - 1);
        de_c   = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        hs_c   = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
        vs_c   = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
        ls_c   = (h_q == '0);
        fs_c   = (h_q == '0) && (v_q == '0);
        h_d    = h_last ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end
        if (load_zero) begin
            h_d = '0;
            v_d = '0;
        end
    end

    // Outputs capture the pre-advance state, so every field describes the same sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            h_q       <= '0;
            v_q       <= '0;
            out_valid <= 1'b0;
            out_hcnt  <= '0;
            out_vcnt  <= '0;
            out_hsync <= ~H_SYNC_POL;
            out_vsync <= ~V_SYNC_POL;
            out_de    <= 1'b0;
            out_ls    <= 1'b0;
            out_fs    <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                h_q       <= h_d;
                v_q       <= v_d;
                out_hcnt  <= h_q;
                out_vcnt  <= v_q;
                out_hsync <= ~(hs_c ^ H_SYNC_POL);
                out_vsync <= ~(vs_c ^ V_SYNC_POL);
                out_de    <= de_c;
                out_ls    <= ls_c;
                out_fs    <= fs_c;
            end
        end
    end

endmodule
